// File: rtl/player_motion.sv
// ---------------------------------------------------------------------------
// player_motion
//
// Generates the player's top-left position for the video controller. Raw
// buttons are synchronised and debounced, the start of each vertical sync
// pulse produces a one-cycle frame tick, and on every tick a slow/fast
// acceleration state machine moves the player. The position is clamped to
// the visible area. Because updates happen only once per frame, inside
// vertical blanking, the position never changes while a frame is drawn.
//
// Ports:
//   clk              in   system clock, single domain
//   rst              in   synchronous active-high reset
//   btns[3:0]        in   raw buttons (async): [0]=up [1]=down [2]=left [3]=right
//   VS               in   vertical sync, active-low
//   player_hStartPos out  player left edge (registered)
//   player_vStartPos out  player top edge (registered)
//   frame_tick       out  one-cycle pulse at each VS falling edge
//   moving           out  high while the motion state is not IDLE
// ---------------------------------------------------------------------------
module player_motion #(
    parameter int H_ACTIVE        = 640,
    parameter int V_ACTIVE        = 480,
    parameter int OBJ_W           = 20,
    parameter int OBJ_H           = 20,
    parameter int H_INIT          = 310,
    parameter int V_INIT          = 230,
    parameter int STEP_SLOW       = 1,
    parameter int STEP_FAST       = 4,
    parameter int FAST_AFTER      = 30,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btns,
    input  logic        VS,
    output logic [31:0] player_hStartPos,
    output logic [31:0] player_vStartPos,
    output logic        frame_tick,
    output logic        moving
);

    // The debounce counter never needs to hold more than DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // hold_cnt saturates at FAST_AFTER; beyond that value it carries no information.
    localparam int HOLD_W = (FAST_AFTER > 1) ? $clog2(FAST_AFTER + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(FAST_AFTER);

    localparam logic [31:0] LIMIT_H = 32'(H_ACTIVE - OBJ_W);
    localparam logic [31:0] LIMIT_V = 32'(V_ACTIVE - OBJ_H);
    localparam logic [31:0] SLOW_STEP = 32'(STEP_SLOW);
    localparam logic [31:0] FAST_STEP = 32'(STEP_FAST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOW = 2'd1,
        FAST = 2'd2
    } state_t;

    logic [3:0]      btn_s1;
    logic [3:0]      btn_s2;
    logic [3:0]      btn_db;
    logic [DB_W-1:0] db_cnt [4];
    logic            vs_s1;
    logic            vs_s2;
    logic            vs_s3;

    state_t          state;
    state_t          next_state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] next_hold;
    logic [31:0]     step;
    logic [31:0]     next_h;
    logic [31:0]     next_v;

    logic            move_up;
    logic            move_down;
    logic            move_left;
    logic            move_right;
    logic            dir_active;

    // Two-flop synchronisers for the buttons and VS; the third VS flop holds
    // the previous synced value so the falling edge can be detected. VS idles
    // high, so its flops reset to 1 to avoid a spurious tick after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1 <= 4'b0000;
            btn_s2 <= 4'b0000;
            vs_s1  <= 1'b1;
            vs_s2  <= 1'b1;
            vs_s3  <= 1'b1;
        end else begin
            btn_s1 <= btns;
            btn_s2 <= btn_s1;
            vs_s1  <= VS;
            vs_s2  <= vs_s1;
            vs_s3  <= vs_s2;
        end
    end

    // Per-button debounce: the counter only runs while the synced level
    // disagrees with the accepted level, so any return to the accepted level
    // (a bounce) restarts the wait. A new level is accepted once it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (btn_s2[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_db[i] <= btn_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Frame tick marks the start of the sync pulse (synced VS going 1 -> 0).
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= vs_s3 & ~vs_s2;
        end
    end

    // Opposing buttons on one axis cancel each other.
    always_comb begin
        move_up    = btn_db[0] & ~btn_db[1];
        move_down  = btn_db[1] & ~btn_db[0];
        move_left  = btn_db[2] & ~btn_db[3];
        move_right = btn_db[3] & ~btn_db[2];
        dir_active = move_up | move_down | move_left | move_right;
    end

    function automatic logic [31:0] dec_pos(input logic [31:0] pos, input logic [31:0] amt);
        return (pos < amt) ? 32'd0 : (pos - amt);
    endfunction

    // The sum is formed one bit wider so a huge position cannot wrap past the limit.
    function automatic logic [31:0] inc_pos(input logic [31:0] pos, input logic [31:0] amt,
                                            input logic [31:0] limit);
        logic [32:0] sum;
        sum = {1'b0, pos} + {1'b0, amt};
        return (sum > {1'b0, limit}) ? limit : sum[31:0];
    endfunction

    // Acceleration state machine and next position. Evaluated every cycle but
    // only committed on frame_tick.
    always_comb begin
        next_state = state;
        next_hold  = hold_cnt;
        step       = SLOW_STEP;
        next_h     = player_hStartPos;
        next_v     = player_vStartPos;

        if (!dir_active) begin
            next_state = IDLE;
            next_hold  = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = SLOW;
                    next_hold  = HOLD_W'(1);
                    step       = SLOW_STEP;
                end
                SLOW: begin
                    next_hold = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
                    if (next_hold >= HOLD_SAT) begin
                        next_state = FAST;
                        step       = FAST_STEP;
                    end else begin
                        next_state = SLOW;
                        step       = SLOW_STEP;
                    end
                end
                FAST: begin
                    next_hold  = (hold_cnt == HOLD_SAT) ? hold_cnt : hold_cnt + 1'b1;
                    next_state = FAST;
                    step       = FAST_STEP;
                end
                default: begin
                    next_state = IDLE;
                    next_hold  = '0;
                end
            endcase

            if (move_left) begin
                next_h = dec_pos(player_hStartPos, step);
            end else if (move_right) begin
                next_h = inc_pos(player_hStartPos, step, LIMIT_H);
            end

            if (move_up) begin
                next_v = dec_pos(player_vStartPos, step);
            end else if (move_down) begin
                next_v = inc_pos(player_vStartPos, step, LIMIT_V);
            end
        end
    end

    // State, position and moving all advance together on the edge that ends
    // the frame_tick pulse; reset on that same edge wins and drops the move.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            hold_cnt         <= '0;
            player_hStartPos <= 32'(H_INIT);
            player_vStartPos <= 32'(V_INIT);
            moving           <= 1'b0;
        end else if (frame_tick) begin
            state            <= next_state;
            hold_cnt         <= next_hold;
            player_hStartPos <= next_h;
            player_vStartPos <= next_v;
            moving           <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// ---------------------------------------------------------------------------
// tb_player_motion
//
// Self-checking bench for player_motion with DEBOUNCE_CYCLES=4, FAST_AFTER=3.
// A frame-level model predicts frame_tick, position and moving every cycle;
// directed scenarios add literal expectations at key points.
// ---------------------------------------------------------------------------
module tb_player_motion;

    localparam int DB_CYC    = 4;
    localparam int FAST_AFT  = 3;
    localparam int LIM_H     = 620;
    localparam int LIM_V     = 460;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btns;
    logic        vs;
    logic [31:0] player_hStartPos;
    logic [31:0] player_vStartPos;
    logic        frame_tick;
    logic        moving;

    int vectors  = 0;
    int failures = 0;

    player_motion #(
        .DEBOUNCE_CYCLES (DB_CYC),
        .FAST_AFTER      (FAST_AFT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btns             (btns),
        .VS               (vs),
        .player_hStartPos (player_hStartPos),
        .player_vStartPos (player_vStartPos),
        .frame_tick       (frame_tick),
        .moving           (moving)
    );

    always #5 clk = ~clk;

    // Model state: accepted buttons are declared by the stimulus once a level
    // has been held long enough to be settled.
    logic [3:0] acc_btns = 4'b0000;
    int         m_h = 310;
    int         m_v = 230;
    int         m_frames = 0;
    bit         m_moving = 1'b0;
    bit         m_tick = 1'b0;
    bit [3:0]   vs_hist = 4'b1111;
    bit         started = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int clamp(input int x, input int hi);
        if (x < 0) return 0;
        if (x > hi) return hi;
        return x;
    endfunction

    // One frame of motion: speed depends on how many consecutive frames a
    // direction has been held.
    task automatic model_frame();
        int dh;
        int dv;
        int spd;
        dh = int'(acc_btns[3]) - int'(acc_btns[2]);
        dv = int'(acc_btns[1]) - int'(acc_btns[0]);
        if (dh == 0 && dv == 0) begin
            m_frames = 0;
            m_moving = 1'b0;
        end else begin
            m_frames++;
            spd = (m_frames >= 2 && m_frames >= FAST_AFT) ? 4 : 1;
            m_h = clamp(m_h + dh * spd, LIM_H);
            m_v = clamp(m_v + dv * spd, LIM_V);
            m_moving = 1'b1;
        end
    endtask

    // Model update on each edge, then compare shortly after the edge.
    // A tick is expected when the VS sample from two edges back is low and
    // the one three edges back is high.
    always @(posedge clk) begin
        if (rst) begin
            started  = 1'b1;
            m_h      = 310;
            m_v      = 230;
            m_frames = 0;
            m_moving = 1'b0;
            m_tick   = 1'b0;
            vs_hist  = 4'b1111;
        end else begin
            if (m_tick) model_frame();
            vs_hist = {vs_hist[2:0], vs};
            m_tick  = !vs_hist[2] && vs_hist[3];
        end
        #1;
        if (started) begin
            check_output("frame_tick", {31'd0, frame_tick}, {31'd0, m_tick});
            check_output("hpos", player_hStartPos, 32'(m_h));
            check_output("vpos", player_vStartPos, 32'(m_v));
            check_output("moving", {31'd0, moving}, {31'd0, m_moving});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a button level and hold it until it is certainly debounced.
    task automatic apply_stimulus(input logic [3:0] b);
        @(negedge clk);
        btns = b;
        wait_cycles(DB_CYC + 6);
        acc_btns = b;
    endtask

    task automatic pulse_frame(input int low_cycles);
        @(negedge clk);
        vs = 1'b0;
        wait_cycles(low_cycles);
        vs = 1'b1;
        wait_cycles(6);
    endtask

    initial begin
        bit seen;
        rst  = 1'b1;
        vs   = 1'b1;
        btns = 4'b0000;
        wait_cycles(2);
        check_output("reset_h", player_hStartPos, 32'd310);
        check_output("reset_v", player_vStartPos, 32'd230);
        check_output("reset_moving", {31'd0, moving}, 32'd0);
        check_output("reset_tick", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        wait_cycles(3);

        // Idle frame, then VS held low for a long time (one tick only).
        pulse_frame(4);
        check_output("idle_h", player_hStartPos, 32'd310);
        pulse_frame(20);
        check_output("idle_long_h", player_hStartPos, 32'd310);

        // Acceleration: 1, 1, then fast steps of 4.
        apply_stimulus(4'b1000);
        for (int i = 0; i < 5; i++) pulse_frame(4);
        check_output("accel_h", player_hStartPos, 32'd324);
        check_output("accel_moving", {31'd0, moving}, 32'd1);

        // Release and re-press.
        apply_stimulus(4'b0000);
        pulse_frame(4);
        check_output("release_h", player_hStartPos, 32'd324);
        check_output("release_moving", {31'd0, moving}, 32'd0);
        apply_stimulus(4'b1000);
        pulse_frame(4);
        check_output("repress_h", player_hStartPos, 32'd325);
        apply_stimulus(4'b0000);
        pulse_frame(4);

        // Bounce on right shorter than the debounce window.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            btns[3] = ~btns[3];
            wait_cycles(1);
        end
        btns = 4'b0000;
        wait_cycles(8);
        pulse_frame(4);
        check_output("bounce_h", player_hStartPos, 32'd325);

        // Up+down cancel, right moves one pixel.
        apply_stimulus(4'b1011);
        pulse_frame(4);
        check_output("cancel_h", player_hStartPos, 32'd326);
        check_output("cancel_v", player_vStartPos, 32'd230);

        // Left into the edge, then down into the limit.
        apply_stimulus(4'b0100);
        for (int i = 0; i < 100; i++) pulse_frame(4);
        check_output("clamp_left", player_hStartPos, 32'd0);
        apply_stimulus(4'b0010);
        for (int i = 0; i < 70; i++) pulse_frame(4);
        check_output("clamp_down", player_vStartPos, 32'd460);

        // VS glitch while reset is held gives no tick.
        @(negedge clk);
        rst = 1'b1;
        vs  = 1'b0;
        wait_cycles(2);
        vs  = 1'b1;
        rst = 1'b0;
        wait_cycles(10);
        check_output("glitch_h", player_hStartPos, 32'd310);

        // Reset on the cycle frame_tick is high drops the pending move.
        apply_stimulus(4'b1000);
        @(negedge clk);
        vs = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) begin
            failures++;
            $display("[TB] FAIL midreset_tick: got no frame_tick, expected one within 10 cycles");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vs  = 1'b1;
        check_output("midreset_h", player_hStartPos, 32'd310);
        check_output("midreset_v", player_vStartPos, 32'd230);
        check_output("midreset_moving", {31'd0, moving}, 32'd0);
        wait_cycles(10);
        pulse_frame(4);
        check_output("after_reset_h", player_hStartPos, 32'd311);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
        $finish;
    end

endmodule
